// File: rtl/add_limb_sequencer.sv
// Wide add/subtract sequencer: drives a shared 32-bit adder one limb per cycle,
// LSB first, and holds the result and flags until the consumer takes them.
module add_limb_sequencer #(
  parameter int LIMBS = 2,
  localparam int W = 32 * LIMBS
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  input  logic          req_sub,
  input  logic          req_cin,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_sum,
  output logic          res_cout,
  output logic          res_ovf,
  output logic          res_zero,
  output logic          res_neg,
  output logic          add_en,
  output logic [31:0]   add_x,
  output logic [31:0]   add_y,
  output logic          add_c0,
  input  logic [31:0]   add_s,
  input  logic          add_c32
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(LIMBS - 1);

  state_t         state_r;
  state_t         state_s;
  logic [1:0]     idx_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           carry_r;
  logic [W-1:0]   sum_r;
  logic [W-1:0]   next_sum_s;
  logic           cout_r;
  logic           ovf_r;
  logic           zero_r;
  logic           neg_r;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (idx_r == LAST_IDX) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE: begin
        if (res_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Adder drive; quiet inputs whenever the shared adder is not ours
  always_comb begin
    add_en = 1'b0;
    add_x  = 32'd0;
    add_y  = 32'd0;
    add_c0 = 1'b0;
    if (state_r == RUN) begin
      add_en = 1'b1;
      add_x  = a_r[32*idx_r +: 32];
      add_y  = b_r[32*idx_r +: 32];
      add_c0 = carry_r;
    end else begin
      add_en = 1'b0;
    end
  end

  // Sum including the limb the adder is producing this cycle; flags read the final one
  always_comb begin
    next_sum_s = sum_r;
    if (state_r == RUN) begin
      next_sum_s[32*idx_r +: 32] = add_s;
    end else begin
      next_sum_s = sum_r;
    end
  end

  // State, operand, accumulator and flag registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            a_r     <= req_a;
            b_r     <= req_sub ? ~req_b : req_b;
            carry_r <= req_sub ^ req_cin;
            idx_r   <= 2'd0;
          end else begin
            idx_r   <= 2'd0;
          end
        end
        RUN: begin
          sum_r   <= next_sum_s;
          carry_r <= add_c32;
          idx_r   <= idx_r + 2'd1;
          if (idx_r == LAST_IDX) begin
            cout_r <= add_c32;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (next_sum_s[W-1] != a_r[W-1]);
            zero_r <= (next_sum_s == {W{1'b0}});
            neg_r  <= next_sum_s[W-1];
          end else begin
            cout_r <= cout_r;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign res_valid = (state_r == DONE);
  assign res_sum   = sum_r;
  assign res_cout  = cout_r;
  assign res_ovf   = ovf_r;
  assign res_zero  = zero_r;
  assign res_neg   = neg_r;

endmodule

// File: tb/tb_add_limb_sequencer.sv
// Bench for add_limb_sequencer (LIMBS=2): arithmetic-level model with a per-cycle
// compare process, plus directed vectors with hand-computed results.
module tb_add_limb_sequencer;

  localparam int LIMBS = 2;
  localparam int W = 32 * LIMBS;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          req_sub = 1'b0;
  logic          req_cin = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_sum;
  logic          res_cout, res_ovf, res_zero, res_neg;
  logic          add_en;
  logic [31:0]   add_x, add_y, add_s;
  logic          add_c0, add_c32;

  int checks = 0;
  int errors = 0;
  logic [31:0] first_y;
  logic        first_c0;

  add_limb_sequencer #(.LIMBS(LIMBS)) dut (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_cin(req_cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
    .res_zero(res_zero), .res_neg(res_neg),
    .add_en(add_en), .add_x(add_x), .add_y(add_y), .add_c0(add_c0),
    .add_s(add_s), .add_c32(add_c32)
  );

  // The shared 32-bit adder
  assign {add_c32, add_s} = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_c0};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: whole-word arithmetic and a cycle countdown of remaining limbs
  logic [W-1:0] m_a, m_b;
  logic         m_c;
  int           m_cnt;
  logic         m_hold;
  logic [W-1:0] m_sum;
  logic         m_cout, m_ovf, m_zero, m_neg;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_cnt  <= 0;
      m_hold <= 1'b0;
    end else if (m_cnt == 0 && !m_hold) begin
      if (req_valid) begin
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   tot;
        be  = req_sub ? ~req_b : req_b;
        ce  = req_sub ^ req_cin;
        tot = {1'b0, req_a} + {1'b0, be} + {{W{1'b0}}, ce};
        m_a    <= req_a;
        m_b    <= be;
        m_c    <= ce;
        m_sum  <= tot[W-1:0];
        m_cout <= tot[W];
        m_ovf  <= ($signed({req_a[W-1], req_a}) + $signed({be[W-1], be}) + $signed({{W{1'b0}}, ce}))
                  != $signed({tot[W-1], tot[W-1:0]});
        m_zero <= (tot[W-1:0] == '0);
        m_neg  <= tot[W-1];
        m_cnt  <= LIMBS;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_hold <= 1'b1;
    end else if (res_ready) begin
      m_hold <= 1'b0;
    end
  end

  function automatic logic carry_into(input int i);
    logic [W:0] one, mask, lo;
    one  = 1;
    mask = (one << (32 * i)) - 1;
    lo   = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + {{W{1'b0}}, m_c};
    return lo[32 * i];
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (clr_n) begin
      chk("req_ready", {{W{1'b0}}, req_ready}, {{W{1'b0}}, (m_cnt == 0 && !m_hold)});
      chk("res_valid", {{W{1'b0}}, res_valid}, {{W{1'b0}}, m_hold});
      chk("add_en", {{W{1'b0}}, add_en}, {{W{1'b0}}, (m_cnt > 0)});
      if (m_cnt > 0) begin
        int i;
        i = LIMBS - m_cnt;
        chk("add_x", {{(W-31){1'b0}}, add_x}, {{(W-31){1'b0}}, m_a[32*i +: 32]});
        chk("add_y", {{(W-31){1'b0}}, add_y}, {{(W-31){1'b0}}, m_b[32*i +: 32]});
        chk("add_c0", {{W{1'b0}}, add_c0}, {{W{1'b0}}, carry_into(i)});
      end else begin
        chk("add_quiet", {{(W-63){1'b0}}, add_x, add_y}, '0);
        chk("add_c0_quiet", {{W{1'b0}}, add_c0}, '0);
      end
      if (m_hold) begin
        chk("res_sum", {1'b0, res_sum}, {1'b0, m_sum});
        chk("res_flags", {{(W-3){1'b0}}, res_cout, res_ovf, res_zero, res_neg},
            {{(W-3){1'b0}}, m_cout, m_ovf, m_zero, m_neg});
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    @(negedge clk);
    req_a = a; req_b = b; req_sub = sub; req_cin = cin; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Send one request, wait for the result, check literals, then release it
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin,
                        input logic [W-1:0] exp_sum, input logic [3:0] exp_flags);
    int n_en, waitc;
    send(a, b, sub, cin);
    n_en = 0; waitc = 0;
    first_y = add_y; first_c0 = add_c0;
    while (!res_valid && waitc < 20) begin
      if (add_en) n_en++;
      @(negedge clk);
      waitc++;
    end
    chk({nm, "_latency"}, waitc, LIMBS);
    chk({nm, "_en_cycles"}, n_en, LIMBS);
    chk({nm, "_sum"}, {1'b0, res_sum}, {1'b0, exp_sum});
    chk({nm, "_flags"}, {res_cout, res_ovf, res_zero, res_neg}, exp_flags);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, "_idle_after"}, {res_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int waitc;
    #12;
    chk("rst_valid_ready", {res_valid, req_ready, add_en}, 3'b010);
    chk("rst_sum", {1'b0, res_sum}, '0);
    chk("rst_flags", {res_cout, res_ovf, res_zero, res_neg}, 4'b0000);
    @(negedge clk);
    clr_n = 1'b1;

    // flags order: cout, ovf, zero, neg
    run_op("add_carry_limb", 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0,
           64'h00000001_00000000, 4'b0000);
    run_op("sub_borrow", 64'd0, 64'd1, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 4'b0001);
    chk("sub_first_y", first_y, 32'hFFFFFFFE);
    chk("sub_first_c0", first_c0, 1'b1);
    run_op("add_ovf", 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0,
           64'h80000000_00000000, 4'b0101);
    run_op("add_wrap_zero", 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b0, 1'b1, 64'd0, 4'b1010);
    run_op("sub_cin", 64'h00000001_00000000, 64'd1, 1'b1, 1'b1,
           64'h00000000_FFFFFFFE, 4'b1000);

    // Backpressure with stray requests while the result is held
    send(64'd5, 64'd3, 1'b0, 1'b0);
    waitc = 0;
    while (!res_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    for (int k = 0; k < 5; k++) begin
      req_a = 64'(k + 100); req_b = 64'd7; req_valid = 1'b1;
      @(negedge clk);
      chk("bp_sum", {1'b0, res_sum}, 65'd8);
      chk("bp_ready_valid", {req_ready, res_valid}, 2'b01);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_release", {req_ready, res_valid}, 2'b10);
    @(negedge clk);
    chk("bp_no_extra", {add_en, req_ready}, 2'b01);

    // Reset in the middle of a run
    send(64'd10, 64'd20, 1'b0, 1'b0);
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_state", {res_valid, add_en, req_ready}, 3'b001);
    chk("midrst_sum", {1'b0, res_sum}, '0);
    @(negedge clk);
    #2 clr_n = 1'b1;
    run_op("after_rst", 64'd3, 64'h00000002_00000004, 1'b0, 1'b0,
           64'h00000002_00000007, 4'b0000);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
